// File: rtl/event_counter_frame_bank_pkg.sv
// Shared definitions for the event counter frame bank.
//   FRAME_HDR     : first byte of every frame
//   pack_state_e  : packer FSM states
//   frame_bytes() : total frame length in bytes (header + seq + all counts)
package event_counter_frame_bank_pkg;

   localparam logic [7:0] FRAME_HDR = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      HDR,
      SEQ,
      DATA
   } pack_state_e;

   function automatic int frame_bytes(input int n_ch, input int cnt_w);
      return 2 + n_ch * cnt_w / 8;
   endfunction

endpackage

// File: rtl/event_counter_frame_bank_sync_byte_fifo.sv
// Single-clock first-word-fall-through byte FIFO.
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en, wr_data    : push port (ignored when full)
//   rd_ready          : consumer takes rd_data when rd_valid is high
//   rd_data, rd_valid : head byte and its valid flag
//   level             : current occupancy in bytes (0..DEPTH)
module sync_byte_fifo #(
   parameter int DEPTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   input  logic                   rd_ready,
   output logic [7:0]             rd_data,
   output logic                   rd_valid,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic        full;
   logic        empty;
   logic        do_write;
   logic        do_read;

   // Pointers carry one extra wrap bit: equal pointers mean empty, equal
   // addresses with differing wrap bits mean full.
   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_write = wr_en && !full;
   assign do_read  = rd_ready && !empty;

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr_reg[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_read)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // Asynchronous read keeps the head byte visible the cycle after it is
   // written; the slot under rd_ptr is never overwritten while it is valid.
   assign rd_data  = mem[rd_ptr_reg[AW-1:0]];
   assign rd_valid = !empty;
   assign level    = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/event_counter_frame_bank.sv
// Multi-channel event counter with windowed snapshots packed into byte frames.
//   clk, rst     : clock, asynchronous active-high reset
//   en           : counting / window enable
//   clear_i      : synchronous clear of counters, window and sat flags
//   event_i      : per-channel event strobes
//   tx_data_o    : FIFO head byte; tx_valid_o flags it; tx_ready_i pops it
//   sat_o        : sticky per-channel saturation flags
//   overflow_o   : sticky, set when a frame is dropped for lack of space
//   fifo_level_o : FIFO occupancy in bytes
// Frame layout: 0xA5, seq, then channel 0..N_CH-1 counts, MSB byte first.
module event_counter_frame_bank
   import event_counter_frame_bank_pkg::*;
#(
   parameter int N_CH       = 8,
   parameter int CNT_W      = 16,
   parameter int WINDOW     = 1024,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        clear_i,
   input  logic [N_CH-1:0]             event_i,
   output logic [7:0]                  tx_data_o,
   output logic                        tx_valid_o,
   input  logic                        tx_ready_i,
   output logic [N_CH-1:0]             sat_o,
   output logic                        overflow_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

   localparam int FRAME_BYTES = frame_bytes(N_CH, CNT_W);
   localparam int DATA_BYTES  = N_CH * CNT_W / 8;
   localparam int TOT_W       = N_CH * CNT_W;
   localparam int WIN_W       = $clog2(WINDOW);
   localparam int IDX_W       = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam int SLOTS       = 2 ** IDX_W;

   // ---------------- window ----------------
   logic [WIN_W-1:0] win_cnt_reg;
   logic             win_end;

   // clear_i outranks the window end, so a clear on the last cycle drops it.
   assign win_end = en && !clear_i && (win_cnt_reg == WIN_W'(WINDOW - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt_reg <= '0;
      end else if (clear_i) begin
         win_cnt_reg <= '0;
      end else if (en) begin
         win_cnt_reg <= win_end ? '0 : win_cnt_reg + 1'b1;
      end
   end

   // ---------------- counters and shadows ----------------
   logic [TOT_W-1:0] shadow_flat;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] shadow_reg;
         logic [CNT_W-1:0] cnt_inc;
         logic             sat_reg;
         logic             at_max;

         assign at_max  = &cnt_reg;
         assign cnt_inc = (event_i[gi] && !at_max) ? cnt_reg + CNT_W'(1) : cnt_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_reg    <= '0;
               shadow_reg <= '0;
               sat_reg    <= 1'b0;
            end else if (clear_i) begin
               cnt_reg <= '0;
               sat_reg <= 1'b0;
            end else if (en) begin
               if (event_i[gi] && at_max) sat_reg <= 1'b1;
               // The snapshot takes the incremented value so the final
               // cycle's event lands in this window, not the next.
               if (win_end) begin
                  shadow_reg <= cnt_inc;
                  cnt_reg    <= '0;
               end else begin
                  cnt_reg <= cnt_inc;
               end
            end
         end

         assign sat_o[gi] = sat_reg;
         // Channel 0 occupies the top bits so bytes emerge in frame order.
         assign shadow_flat[TOT_W-1-gi*CNT_W -: CNT_W] = shadow_reg;
      end

      // Byte view of the snapshot; padding slots are never selected.
      logic [7:0] data_byte_arr [SLOTS];
      for (genvar gi = 0; gi < SLOTS; gi++) begin : g_byte
         if (gi < DATA_BYTES) begin : g_used
            assign data_byte_arr[gi] = shadow_flat[TOT_W-1-8*gi -: 8];
         end else begin : g_pad
            assign data_byte_arr[gi] = 8'h00;
         end
      end
   endgenerate

   // ---------------- packer ----------------
   pack_state_e                 state_reg;
   pack_state_e                 state_next;
   logic                        snap_pend_reg;
   logic [7:0]                  seq_reg;
   logic                        overflow_reg;
   logic [IDX_W-1:0]            byte_idx_reg;
   logic                        push;
   logic [7:0]                  push_byte;
   logic                        frame_fits;
   logic                        last_byte;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;

   // Level can only fall between this check and the last push, so a frame
   // that fits here is written in full.
   assign frame_fits = (FIFO_DEPTH - int'(fifo_level)) >= FRAME_BYTES;
   assign last_byte  = (byte_idx_reg == IDX_W'(DATA_BYTES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      push       = 1'b0;
      push_byte  = FRAME_HDR;
      case (state_reg)
         IDLE:  if (snap_pend_reg) state_next = CHECK;
         CHECK: state_next = frame_fits ? HDR : IDLE;
         HDR: begin
            push       = 1'b1;
            push_byte  = FRAME_HDR;
            state_next = SEQ;
         end
         SEQ: begin
            push       = 1'b1;
            push_byte  = seq_reg;
            state_next = DATA;
         end
         DATA: begin
            push      = 1'b1;
            push_byte = data_byte_arr[byte_idx_reg];
            if (last_byte) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_pend_reg <= 1'b0;
         seq_reg       <= '0;
         overflow_reg  <= 1'b0;
         byte_idx_reg  <= '0;
      end else begin
         if (win_end)
            snap_pend_reg <= 1'b1;
         else if (state_reg == IDLE && snap_pend_reg)
            snap_pend_reg <= 1'b0;

         // A dropped frame still burns a sequence number.
         if ((state_reg == CHECK && !frame_fits) || state_reg == SEQ)
            seq_reg <= seq_reg + 1'b1;

         if (state_reg == CHECK && !frame_fits)
            overflow_reg <= 1'b1;

         if (state_reg == SEQ)
            byte_idx_reg <= '0;
         else if (state_reg == DATA)
            byte_idx_reg <= byte_idx_reg + 1'b1;
      end
   end

   assign overflow_o   = overflow_reg;
   assign fifo_level_o = fifo_level;

   sync_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (push),
      .wr_data  (push_byte),
      .rd_ready (tx_ready_i),
      .rd_data  (tx_data_o),
      .rd_valid (tx_valid_o),
      .level    (fifo_level)
   );

endmodule
